// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bus for instr_prefetch_queue: redirect input, instruction memory
// request/ack channel and the valid/ready decode channel.
interface instr_prefetch_queue_if #(
   parameter int ADDR_W  = 10,
   parameter int INSTR_W = 32
) ();
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: one outstanding imem request, DEPTH-entry {pc, instr}
// FIFO, redirect flush. Define PREFETCH_STATS_EN to add stat_flushed/stat_stall.
module instr_prefetch_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 10,
   parameter int INSTR_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   instr_prefetch_queue_if.master bus
`ifdef PREFETCH_STATS_EN
   ,
   output logic [15:0]            stat_flushed,
   output logic [15:0]            stat_stall
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DISCARD
   } state_t;

   state_t             r_state;
   logic               r_imem_req;
   logic [ADDR_W-1:0]  r_imem_addr;
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]  r_fifo_pc    [DEPTH];
   logic [INSTR_W-1:0] r_fifo_instr [DEPTH];

   logic               w_out_valid;
   logic               w_pop;
   logic               w_push;
   logic [CNT_W-1:0]   w_count_next;
   logic               w_issue;
   logic [ADDR_W-1:0]  w_fetch_pc_inc;

   // NOTE: combinational logic uses blocking '=' and assigns every output a
   // default first, so no path leaves a signal unassigned and infers a latch.
   always_comb begin
      w_out_valid    = (r_count != '0);
      w_pop          = w_out_valid && bus.out_ready && !bus.redirect_valid;
      w_push         = (r_state == ST_WAIT) && bus.imem_ack && !bus.redirect_valid;
      w_count_next   = r_count;
      if (w_push) w_count_next = w_count_next + CNT_W'(1);
      if (w_pop)  w_count_next = w_count_next - CNT_W'(1);
      // A new request may only start if its response is guaranteed a free slot.
      w_issue        = (w_count_next < CNT_W'(DEPTH));
      w_fetch_pc_inc = r_fetch_pc + ADDR_W'(1);
   end

   assign bus.imem_req  = r_imem_req;
   assign bus.imem_addr = r_imem_addr;
   assign bus.out_valid = w_out_valid;
   assign bus.out_instr = w_out_valid ? r_fifo_instr[r_rd_ptr] : '0;
   assign bus.out_pc    = w_out_valid ? r_fifo_pc[r_rd_ptr]    : '0;

   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
         r_fetch_pc  <= '0;
         r_count     <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= bus.redirect_pc;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         if (r_state != ST_IDLE && !bus.imem_ack) begin
            // Old request still in flight: keep it on the bus and drop its data.
            r_state <= ST_DISCARD;
         end else begin
            r_state     <= ST_WAIT;
            r_imem_req  <= 1'b1;
            r_imem_addr <= bus.redirect_pc;
         end
      end else begin
         r_count <= w_count_next;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state     <= ST_WAIT;
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= r_fetch_pc;
               end
            end
            ST_WAIT: begin
               if (bus.imem_ack) begin
                  r_fetch_pc <= w_fetch_pc_inc;
                  if (w_issue) begin
                     r_imem_addr <= w_fetch_pc_inc;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_imem_req <= 1'b0;
                  end
               end
            end
            ST_DISCARD: begin
               if (bus.imem_ack) begin
                  r_state     <= ST_WAIT;
                  r_imem_addr <= r_fetch_pc;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_imem_req <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: FIFO storage has no reset; r_count gates every read, so stale
   // contents are never visible and the array can map to plain RAM.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_imem_addr;
         r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [15:0] r_stat_flushed;
   logic [15:0] r_stat_stall;
   logic [16:0] w_flush_sum;

   // A redirect in WAIT throws away the response of the outstanding request too.
   always_comb begin
      w_flush_sum = {1'b0, r_stat_flushed} + 17'(r_count) + 17'(r_state == ST_WAIT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stat_flushed <= '0;
         r_stat_stall   <= '0;
      end else begin
         if (bus.redirect_valid) begin
            r_stat_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
         end
         if (!w_out_valid && r_state != ST_IDLE && r_stat_stall != 16'hFFFF) begin
            r_stat_stall <= r_stat_stall + 16'd1;
         end
      end
   end

   assign stat_flushed = r_stat_flushed;
   assign stat_stall   = r_stat_stall;
`endif
endmodule
